// File: rtl/mult_share_arb.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters.
// Optional per-requester grant counters are built when MULT_ARB_STATS_EN is defined.
module mult_share_arb #(
  parameter int W    = 35,
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int CW   = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ_VALID,
  input  logic [NREQ*W-1:0]   REQ_A,
  input  logic [NREQ*W-1:0]   REQ_B,
  output logic [NREQ-1:0]     REQ_READY,
  output logic [W-1:0]        MUL_A,
  output logic [W-1:0]        MUL_B,
  input  logic [2*W-1:0]      MUL_P,
  output logic [NREQ-1:0]     RSP_VALID,
  output logic [2*W-1:0]      RSP_PROD,
  output logic [CW-1:0]       IN_FLIGHT,
  output logic                BUSY
`ifdef MULT_ARB_STATS_EN
  ,
  input  logic                STATS_CLR,
  output logic [NREQ*16-1:0]  GRANT_CNT
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          grant_idx;
  logic [NREQ-1:0]        grant_oh;
  logic [W-1:0]           sel_a;
  logic [W-1:0]           sel_b;
  logic                   accept;
  logic                   rsp_load;
  logic [LAT:0]           tag_vld;
  logic [LAT:0][IW-1:0]   tag_id;

  // Rotating priority search starting at rr_ptr; the mux picks the winner's operands.
  always_comb begin
    logic [IW:0] pos;
    logic        found;
    // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
    grant_oh  = '0;
    grant_idx = '0;
    sel_a     = '0;
    sel_b     = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (!found && REQ_VALID[pos[IW-1:0]]) begin
        found                  = 1'b1;
        grant_idx              = pos[IW-1:0];
        grant_oh[pos[IW-1:0]]  = 1'b1;
      end
    end
    if (RST) grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = REQ_A[i*W +: W];
        sel_b = REQ_B[i*W +: W];
      end
    end
  end

  assign REQ_READY = grant_oh;
  assign accept    = |grant_oh;
  assign rsp_load  = tag_vld[LAT];
  assign BUSY      = |IN_FLIGHT;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr    <= '0;
      MUL_A     <= '0;
      MUL_B     <= '0;
      tag_vld   <= '0;
      tag_id    <= '0;
      RSP_VALID <= '0;
      RSP_PROD  <= '0;
      IN_FLIGHT <= '0;
    end else begin
      if (accept) begin
        MUL_A  <= sel_a;
        MUL_B  <= sel_b;
        rr_ptr <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
      // The tag shifts alongside the multiplier so stage LAT lines up with MUL_P.
      tag_vld <= {tag_vld[LAT-1:0], accept};
      tag_id  <= {tag_id[LAT-1:0], grant_idx};
      if (rsp_load) begin
        RSP_VALID <= NREQ'(1) << tag_id[LAT];
        RSP_PROD  <= MUL_P;
      end else begin
        RSP_VALID <= '0;
      end
      case ({accept, rsp_load})
        2'b10:   IN_FLIGHT <= IN_FLIGHT + 1'b1;
        2'b01:   IN_FLIGHT <= IN_FLIGHT - 1'b1;
        default: IN_FLIGHT <= IN_FLIGHT;
      endcase
    end
  end

`ifdef MULT_ARB_STATS_EN
  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GRANT_CNT <= '0;
    end else if (STATS_CLR) begin
      GRANT_CNT <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant_oh[i] && (GRANT_CNT[i*16 +: 16] != 16'hFFFF))
          GRANT_CNT[i*16 +: 16] <= GRANT_CNT[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: behavioural requesters, multiplier and response scoreboard.
// Define MULT_ARB_STATS_EN to also exercise the grant counters.
module tb_mult_share_arb;
  localparam int W    = 35;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  localparam int CW   = 3;
  localparam int PW   = 2 * W;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ*W-1:0] REQ_A;
  logic [NREQ*W-1:0] REQ_B;
  logic [NREQ-1:0]   REQ_READY;
  logic [W-1:0]      MUL_A;
  logic [W-1:0]      MUL_B;
  logic [PW-1:0]     MUL_P;
  logic [NREQ-1:0]   RSP_VALID;
  logic [PW-1:0]     RSP_PROD;
  logic [CW-1:0]     IN_FLIGHT;
  logic              BUSY;
`ifdef MULT_ARB_STATS_EN
  logic              STATS_CLR;
  logic [NREQ*16-1:0] GRANT_CNT;
`endif

  mult_share_arb #(.W(W), .NREQ(NREQ), .LAT(LAT), .CW(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_READY (REQ_READY),
    .MUL_A     (MUL_A),
    .MUL_B     (MUL_B),
    .MUL_P     (MUL_P),
    .RSP_VALID (RSP_VALID),
    .RSP_PROD  (RSP_PROD),
    .IN_FLIGHT (IN_FLIGHT),
    .BUSY      (BUSY)
`ifdef MULT_ARB_STATS_EN
    ,
    .STATS_CLR (STATS_CLR),
    .GRANT_CNT (GRANT_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External multiplier: LAT edges from sampling MUL_A/MUL_B to MUL_P.
  logic [PW-1:0] mpipe [LAT];
  always @(posedge CLK) begin
    mpipe[0] <= PW'(MUL_A) * PW'(MUL_B);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign MUL_P = mpipe[LAT-1];

  typedef struct {
    int            due;
    int            id;
    logic [PW-1:0] prod;
  } rsp_t;

  rsp_t            exp_q[$];
  int              ptr;
  bit              pend [NREQ];
  logic [W-1:0]    a_v  [NREQ];
  logic [W-1:0]    b_v  [NREQ];
  int              cyc;
  int              errors;
  int              checks;
  logic [NREQ-1:0] last_ready;
  logic [W-1:0]    max_op;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i]       = pend[i];
      REQ_A[i*W +: W]    = a_v[i];
      REQ_B[i*W +: W]    = b_v[i];
    end
  endtask

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[i] = 1'b1;
    a_v[i]  = a;
    b_v[i]  = b;
    drive();
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return max_op;
      default: return r[W-1:0];
    endcase
  endfunction

  // Model grant: first pending requester at or after ptr, wrapping.
  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++)
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance, then let requesters react.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_oh;
    @(negedge CLK);
    if (RST) begin
      exp_q.delete();
      ptr = 0;
      check("rst_ready",     PW'(REQ_READY), '0);
      check("rst_rsp_valid", PW'(RSP_VALID), '0);
      check("rst_in_flight", PW'(IN_FLIGHT), '0);
      check("rst_busy",      PW'(BUSY),      '0);
    end else begin
      exp_oh = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_oh[exp_q[0].id] = 1'b1;
        check("rsp_valid", PW'(RSP_VALID), PW'(exp_oh));
        check("rsp_prod",  RSP_PROD,       exp_q[0].prod);
        void'(exp_q.pop_front());
      end else begin
        check("rsp_idle", PW'(RSP_VALID), '0);
      end
      check("in_flight", PW'(IN_FLIGHT), PW'(exp_q.size()));
      check("busy",      PW'(BUSY),      PW'(exp_q.size() != 0));
      g      = model_grant();
      exp_oh = '0;
      if (g >= 0) exp_oh[g] = 1'b1;
      check("grant", PW'(REQ_READY), PW'(exp_oh));
      if (g >= 0) begin
        exp_q.push_back('{cyc + LAT + 2, g, PW'(a_v[g]) * PW'(b_v[g])});
        ptr = (g + 1) % NREQ;
      end
    end
    last_ready = REQ_READY;
    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (last_ready[i]) pend[i] = 1'b0;
    drive();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    ptr        = 0;
    max_op     = '1;
    last_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      a_v[i]  = '0;
      b_v[i]  = '0;
    end
`ifdef MULT_ARB_STATS_EN
    STATS_CLR = 1'b0;
`endif
    RST = 1'b1;
    drive();

    // Reset held two cycles with every requester valid.
    for (int i = 0; i < NREQ; i++) raise(i, W'(i + 3), W'(i + 5));
    step();
    check("rst_mul_a",    PW'(MUL_A), '0);
    check("rst_rsp_prod", RSP_PROD,   '0);
    step();
    RST = 1'b0;
    step();
    check("first_grant", PW'(last_ready), PW'(4'b0001));
    drain(12);
    check("drain_idle", PW'(IN_FLIGHT), '0);

    // Round robin with all four requesters continuously valid.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) raise(i, rand_op(), rand_op());
      step();
      check("rr_order", PW'(last_ready), PW'(1) << (k % NREQ));
    end
    drain(12);

    // Single request with all-ones operands exercises the top product bit.
    raise(1, max_op, max_op);
    step();
    check("single_grant", PW'(last_ready), PW'(4'b0010));
    drain(LAT + 4);
    check("single_done", PW'(IN_FLIGHT), '0);

    // Pointer now sits at 2: requesters 0 and 1 force a wrap then a step.
    raise(0, rand_op(), rand_op());
    raise(1, rand_op(), rand_op());
    step();
    check("wrap_grant0", PW'(last_ready), PW'(4'b0001));
    step();
    check("wrap_grant1", PW'(last_ready), PW'(4'b0010));
    drain(10);

    // Reset pulse with three requests in flight: nothing may come back.
    raise(0, rand_op(), rand_op());
    raise(1, rand_op(), rand_op());
    raise(2, rand_op(), rand_op());
    drain(3);
    drain(2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    drain(LAT + 6);
    check("rst_mid_idle", PW'(IN_FLIGHT), '0);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) raise(i, rand_op(), rand_op());
      step();
    end
    drain(NREQ + LAT + 6);
    check("final_idle", PW'(IN_FLIGHT), '0);

`ifdef MULT_ARB_STATS_EN
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      if (!pend[0]) raise(0, W'(k), W'(3));
      step();
    end
    drain(LAT + 4);
    check("cnt_saturate", PW'(GRANT_CNT[15:0]), PW'(16'hFFFF));
    STATS_CLR = 1'b1;
    step();
    STATS_CLR = 1'b0;
    check("cnt_clear", PW'(GRANT_CNT), '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
